uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between N_REQ byte-stream requesters. Each requester sends a frame (bytes until last) over a valid/ready interface. The frame goes out as a header byte carrying the requester ID, then the payload, then an optional XOR checksum. Sits between client blocks and the uart TXbuffer/TXstart/TXbusy port, in the same clock domain.

Parameters:
N_REQ, 4, number of requesters (2..16)
CHECKSUM_EN, 1, 1 = append XOR checksum byte after each frame's last payload byte
HDR_TAG, 4'hA, upper nibble of the header byte

Ports:
CLK  input  1  system clock; all logic on posedge
RSTn  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester byte valid
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  N_REQ  marks the final payload byte of a frame
req_ready  output  N_REQ  per-requester byte accept
TXbuffer  output  8  byte to the UART, registered
TXstart  output  1  one-cycle start pulse to the UART, registered
TXbusy  input  1  UART transmitter busy
grant_id  output  $clog2(N_REQ)  ID of the current or last granted requester
active  output  1  high while a frame is owned (HDR through CSUM)

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=0, TXbuffer=0, TXstart=0, grant_id=0, active=0, rr pointer=0, checksum=0.
- Main states: IDLE, HDR, PAYLOAD, CSUM.
- Each non-IDLE state has sub-phases LOAD, START, WAIT_BUSY, WAIT_IDLE.
- IDLE: grant only when TXbusy=0 and some req_valid=1.
  - Round-robin winner is the first valid index at or after the pointer, wrapping.
  - On grant: grant_id<=winner, pointer<=winner+1 (mod N_REQ), active<=1, checksum<=0, go HDR/LOAD.
- HDR/LOAD: TXbuffer<={HDR_TAG, grant_id zero-extended to 4 bits}, then START.
- START: TXstart=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: hold until TXbusy=1, then WAIT_IDLE.
- WAIT_IDLE: hold until TXbusy=0, then advance:
  - after HDR -> PAYLOAD/LOAD;
  - after a payload byte -> PAYLOAD/LOAD, or CSUM/LOAD if that byte had last and CHECKSUM_EN=1, or IDLE if last and CHECKSUM_EN=0;
  - after CSUM -> IDLE with active<=0.
- PAYLOAD/LOAD:
  - req_ready[grant_id]=1; all other req_ready bits are 0.
  - req_ready does not depend on req_valid.
  - Transfer occurs when req_valid[grant_id]=1 in that cycle: TXbuffer<=byte, checksum<=checksum^byte, latch last flag, go START.
  - With no valid byte, stay in LOAD indefinitely. The line idles between bytes and ownership is kept.
- CSUM/LOAD: TXbuffer<=checksum, then START.
- Latency: req_valid rising in IDLE (UART idle) gives header TXstart 2 cycles later (grant cycle, LOAD cycle).
- Only the granted requester's req_valid and req_last are observed. Other requesters' valid changes mid-frame have no effect.
- req_last is sampled only on the transferring beat.
- At most one req_ready bit is high in any cycle. TXstart is never high while TXbusy=1.
- Reset mid-frame: the controller returns to IDLE immediately. The UART byte in flight finishes on its own, and IDLE waits for TXbusy=0 before re-granting. The partial frame is dropped and its requester must resend.
- Single requester: the pointer still advances, and that requester wins again next frame.

Decomposition:
- Package uart_sched_pkg: main state enum, phase enum, HDR_TAG default, and a function computing the grant-id width.
- One sub-module, rr_arbiter: combinational round-robin pick (valid vector and pointer in, winner index and any-valid out). The pointer register lives in the parent.

Test Plan:
- Single frame: requester 2 sends 0x11, 0x22 (last on 0x22), CHECKSUM_EN=1.
  -> UART bytes 0xA2, 0x11, 0x22, 0x33; four TXstart pulses; active drops after 0x33 completes.
- Contention: requesters 0 and 3 both valid in IDLE, pointer=0.
  -> frame 0 goes first and frame 3 immediately after.
  -> next time both are valid, pointer=1, so 3 wins before 0.
- Stall: requester 1 deasserts valid for 50 cycles mid-frame.
  -> req_ready[1] stays high, no TXstart, no other grant; the frame resumes on revalid.
- CHECKSUM_EN=0, requester 0 sends single byte 0x5A with last.
  -> UART bytes 0xA0, 0x5A only.
- Reset asserted during WAIT_IDLE of the payload byte.
  -> outputs return to their reset values asynchronously.
  -> with a requester valid and TXbusy still 1, no TXstart occurs until TXbusy=0; then a new header is sent.
- Protocol checker running throughout all tests.
  -> never more than one req_ready bit high; never TXstart while TXbusy=1; TXstart never high for two consecutive cycles.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART TX scheduler
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM
    } main_state_t;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_START,
        PH_WAIT_BUSY,
        PH_WAIT_IDLE
    } phase_t;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, first valid index at or after ptr
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest valid index wins last.
    always_comb begin
        winner    = '0;
        idx       = 0;
        any_valid = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (valid[idx]) begin
                winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter between N_REQ framed byte streams
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         N_REQ       = 4,
    parameter bit         CHECKSUM_EN = 1'b1,
    parameter logic [3:0] HDR_TAG     = HDR_TAG_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [8*N_REQ-1:0]          req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [7:0]                  TXbuffer,
    output logic                        TXstart,
    input  logic                        TXbusy,
    output logic [id_width(N_REQ)-1:0]  grant_id,
    output logic                        active
);

    localparam int GW = id_width(N_REQ);

    main_state_t   state, state_n;
    phase_t        phase, phase_n;
    logic [GW-1:0] ptr, ptr_n;
    logic [GW-1:0] gid_n;
    logic [GW-1:0] arb_winner;
    logic          arb_any;
    logic [7:0]    csum, csum_n;
    logic [7:0]    txbuf_n;
    logic          txstart_n;
    logic          active_n;
    logic          last_q, last_n;
    logic [7:0]    sel_data;
    logic          sel_valid;
    logic          sel_last;

    rr_arbiter #(
        .N (N_REQ),
        .W (GW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .winner    (arb_winner),
        .any_valid (arb_any)
    );

    // Only the owner's lane is ever observed; other requesters cannot disturb a frame.
    assign sel_data  = req_data[int'(grant_id) * 8 +: 8];
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];

    always_comb begin
        req_ready = '0;
        if (state == ST_PAYLOAD && phase == PH_LOAD) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        ptr_n     = ptr;
        gid_n     = grant_id;
        csum_n    = csum;
        txbuf_n   = TXbuffer;
        txstart_n = 1'b0;
        active_n  = active;
        last_n    = last_q;

        if (state == ST_IDLE) begin
            // Waiting for TXbusy=0 also covers a byte still draining after a reset.
            if (!TXbusy && arb_any) begin
                gid_n    = arb_winner;
                ptr_n    = (arb_winner == GW'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;
                active_n = 1'b1;
                csum_n   = 8'h00;
                state_n  = ST_HDR;
                phase_n  = PH_LOAD;
            end
        end else begin
            case (phase)
                PH_LOAD: begin
                    case (state)
                        ST_HDR: begin
                            txbuf_n   = {HDR_TAG, 4'(grant_id)};
                            txstart_n = 1'b1;
                            phase_n   = PH_START;
                        end
                        ST_PAYLOAD: begin
                            if (sel_valid) begin
                                txbuf_n   = sel_data;
                                csum_n    = csum ^ sel_data;
                                last_n    = sel_last;
                                txstart_n = 1'b1;
                                phase_n   = PH_START;
                            end
                        end
                        default: begin
                            txbuf_n   = csum;
                            txstart_n = 1'b1;
                            phase_n   = PH_START;
                        end
                    endcase
                end
                PH_START: begin
                    phase_n = PH_WAIT_BUSY;
                end
                PH_WAIT_BUSY: begin
                    if (TXbusy) begin
                        phase_n = PH_WAIT_IDLE;
                    end
                end
                PH_WAIT_IDLE: begin
                    if (!TXbusy) begin
                        phase_n = PH_LOAD;
                        case (state)
                            ST_HDR: begin
                                state_n = ST_PAYLOAD;
                            end
                            ST_PAYLOAD: begin
                                if (last_q) begin
                                    if (CHECKSUM_EN) begin
                                        state_n = ST_CSUM;
                                    end else begin
                                        state_n  = ST_IDLE;
                                        active_n = 1'b0;
                                    end
                                end
                            end
                            default: begin
                                state_n  = ST_IDLE;
                                active_n = 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    phase_n = PH_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            phase    <= PH_LOAD;
            ptr      <= '0;
            grant_id <= '0;
            csum     <= 8'h00;
            TXbuffer <= 8'h00;
            TXstart  <= 1'b0;
            active   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            ptr      <= ptr_n;
            grant_id <= gid_n;
            csum     <= csum_n;
            TXbuffer <= txbuf_n;
            TXstart  <= txstart_n;
            active   <= active_n;
            last_q   <= last_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        CLK  = 1'b0;
    logic        RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic [3:0]  v0 = '0, l0 = '0, rr0;
    logic [31:0] d0 = '0;
    logic [7:0]  TXbuffer0;
    logic        TXstart0, TXbusy0, active0;
    logic [1:0]  grant0;

    logic [3:0]  v1 = '0, l1 = '0, rr1;
    logic [31:0] d1 = '0;
    logic [7:0]  TXbuffer1;
    logic        TXstart1, TXbusy1, active1;
    logic [1:0]  grant1;

    uart_tx_scheduler #(.N_REQ(4), .CHECKSUM_EN(1'b1), .HDR_TAG(4'hA)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .req_valid(v0), .req_data(d0), .req_last(l0),
        .req_ready(rr0), .TXbuffer(TXbuffer0), .TXstart(TXstart0), .TXbusy(TXbusy0),
        .grant_id(grant0), .active(active0)
    );

    uart_tx_scheduler #(.N_REQ(4), .CHECKSUM_EN(1'b0), .HDR_TAG(4'hA)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .req_valid(v1), .req_data(d1), .req_last(l1),
        .req_ready(rr1), .TXbuffer(TXbuffer1), .TXstart(TXstart1), .TXbusy(TXbusy1),
        .grant_id(grant1), .active(active1)
    );

    // UART models: capture the byte on TXstart, then stay busy for busy_len cycles.
    int busy_len0 = 4, busy_len1 = 4;
    int bcnt0 = 0, bcnt1 = 0;
    logic [7:0] log0[$];
    logic [7:0] log1[$];

    always @(posedge CLK) begin
        if (TXstart0) begin
            log0.push_back(TXbuffer0);
            bcnt0 <= busy_len0;
        end else if (bcnt0 != 0) begin
            bcnt0 <= bcnt0 - 1;
        end
        if (TXstart1) begin
            log1.push_back(TXbuffer1);
            bcnt1 <= busy_len1;
        end else if (bcnt1 != 0) begin
            bcnt1 <= bcnt1 - 1;
        end
    end
    assign TXbusy0 = (bcnt0 != 0);
    assign TXbusy1 = (bcnt1 != 0);

    int n_tests = 0;
    int n_fail  = 0;
    int tmo     = 0;
    int proto_viol = 0;
    logic ps0 = 1'b0, ps1 = 1'b0;

    always @(negedge CLK) begin
        proto_viol <= proto_viol
            + int'($countones(rr0) > 1) + int'($countones(rr1) > 1)
            + int'(TXstart0 && TXbusy0) + int'(TXstart1 && TXbusy1)
            + int'(TXstart0 && ps0) + int'(TXstart1 && ps1);
        ps0 <= TXstart0;
        ps1 <= TXstart1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input int dut, input string name, input int n, input logic [63:0] exp);
        int sz;
        sz = (dut == 0) ? log0.size() : log1.size();
        check({name, "_count"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            check($sformatf("%s_b%0d", name, i), (dut == 0) ? log0[i] : log1[i], exp[8*i +: 8]);
        end
    endtask

    task automatic send_byte(input int dut, input int id, input logic [7:0] b, input logic last);
        int n;
        n = 0;
        if (dut == 0) begin
            d0[8*id +: 8] = b; l0[id] = last; v0[id] = 1'b1;
        end else begin
            d1[8*id +: 8] = b; l1[id] = last; v1[id] = 1'b1;
        end
        while (!((dut == 0) ? rr0[id] : rr1[id]) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) tmo++;
        @(posedge CLK);
        #1;
        if (dut == 0) begin
            v0[id] = 1'b0; l0[id] = 1'b0;
        end else begin
            v1[id] = 1'b0; l1[id] = 1'b0;
        end
    endtask

    task automatic send_frame(input int dut, input int id, input int len, input logic [31:0] data);
        for (int j = 0; j < len; j++) begin
            send_byte(dut, id, data[8*j +: 8], j == len - 1);
        end
    endtask

    task automatic wait_done(input int dut);
        int n;
        n = 0;
        while (((dut == 0) ? active0 : active1) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) tmo++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        log0.delete();
        log1.delete();
    endtask

    typedef struct {
        int          id;
        int          len;
        logic [31:0] data;
        logic [7:0]  csum;
        logic [7:0]  hdr;
    } frame_t;

    frame_t      tbl[4];
    logic [63:0] exp;
    int          bad_rdy, bad_start, bad_gid, bad, n;

    initial begin
        tbl[0] = '{1, 3, 32'h0004_0201, 8'h07, 8'hA1};
        tbl[1] = '{3, 1, 32'h0000_00FF, 8'hFF, 8'hA3};
        tbl[2] = '{0, 4, 32'h7856_3412, 8'h08, 8'hA0};
        tbl[3] = '{2, 2, 32'h0000_C33C, 8'hFF, 8'hA2};

        repeat (3) @(negedge CLK);
        check("rst_ready", rr0, 0);
        check("rst_txbuffer", TXbuffer0, 0);
        check("rst_txstart", TXstart0, 0);
        check("rst_grant", grant0, 0);
        check("rst_active", active0, 0);
        RSTn = 1'b1;

        // Single frame from requester 2 with header latency check
        @(negedge CLK);
        fork
            send_frame(0, 2, 2, 32'h0000_2211);
            begin
                @(negedge CLK);
                check("lat_txstart_c1", TXstart0, 0);
                check("lat_grant", grant0, 2);
                check("lat_active", active0, 1);
                @(negedge CLK);
                check("lat_txstart_c2", TXstart0, 1);
                check("lat_hdr", TXbuffer0, 8'hA2);
            end
        join
        wait_done(0);
        check("active_drop_busy", TXbusy0, 0);
        check_log(0, "single", 4, 64'h33_22_11_A2);

        // Table-driven frames
        for (int t = 0; t < 4; t++) begin
            log0.delete();
            send_frame(0, tbl[t].id, tbl[t].len, tbl[t].data);
            wait_done(0);
            exp = '0;
            exp[7:0] = tbl[t].hdr;
            for (int j = 0; j < tbl[t].len; j++) exp[8*(j+1) +: 8] = tbl[t].data[8*j +: 8];
            exp[8*(tbl[t].len+1) +: 8] = tbl[t].csum;
            check_log(0, $sformatf("tbl%0d", t), tbl[t].len + 2, exp);
        end

        // Checksum disabled
        send_frame(1, 0, 1, 32'h0000_005A);
        wait_done(1);
        check_log(1, "nocsum", 2, 64'h5A_A0);

        // Contention from reset pointer 0, then from pointer 1
        do_reset();
        @(negedge CLK);
        fork
            send_byte(0, 0, 8'h10, 1'b1);
            send_byte(0, 3, 8'h30, 1'b1);
        join
        wait_done(0);
        check_log(0, "cont_p0", 6, 64'h30_30_A3_10_10_A0);
        log0.delete();
        send_byte(0, 0, 8'h20, 1'b1);
        wait_done(0);
        log0.delete();
        @(negedge CLK);
        fork
            send_byte(0, 0, 8'h21, 1'b1);
            send_byte(0, 3, 8'h31, 1'b1);
        join
        wait_done(0);
        check_log(0, "cont_p1", 6, 64'h21_21_A0_31_31_A3);

        // Stall mid-frame for 50 cycles while another requester waits
        log0.delete();
        send_byte(0, 1, 8'h01, 1'b0);
        n = 0;
        while (!rr0[1] && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) tmo++;
        d0[23:16] = 8'h99;
        v0[2] = 1'b1;
        bad_rdy = 0; bad_start = 0; bad_gid = 0;
        repeat (50) begin
            @(negedge CLK);
            if (rr0 !== 4'b0010) bad_rdy++;
            if (TXstart0) bad_start++;
            if (grant0 !== 2'd1) bad_gid++;
        end
        check("stall_ready", bad_rdy, 0);
        check("stall_txstart", bad_start, 0);
        check("stall_grant", bad_gid, 0);
        v0[2] = 1'b0;
        send_byte(0, 1, 8'h02, 1'b0);
        send_byte(0, 1, 8'h04, 1'b1);
        wait_done(0);
        check_log(0, "stall", 5, 64'h07_04_02_01_A1);

        // Reset while the payload byte is in flight
        busy_len0 = 20;
        log0.delete();
        send_byte(0, 2, 8'h44, 1'b0);
        @(negedge CLK);
        check("mid_txstart", TXstart0, 1);
        check("mid_txbuffer", TXbuffer0, 8'h44);
        repeat (3) @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_txbuffer", TXbuffer0, 0);
        check("async_txstart", TXstart0, 0);
        check("async_active", active0, 0);
        check("async_grant", grant0, 0);
        check("async_ready", rr0, 0);
        check("inflight_busy", TXbusy0, 1);
        @(negedge CLK);
        RSTn = 1'b1;
        log0.delete();
        busy_len0 = 4;
        fork
            send_byte(0, 2, 8'h55, 1'b1);
            begin
                bad = 0;
                n = 0;
                while (TXbusy0 && n < 100) begin
                    if (TXstart0) bad++;
                    @(negedge CLK);
                    n++;
                end
                check("busy_held_after_reset", n > 0, 1);
                check("no_start_while_busy", bad, 0);
            end
        join
        wait_done(0);
        check_log(0, "post_reset", 3, 64'h55_55_A2);

        repeat (2) @(negedge CLK);
        check("timeouts", tmo, 0);
        check("protocol", proto_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
